nano_loader: RTL

NANO_LOADER -- requirements
Module: nano_loader

---
 rtl/nano_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/nano_loader.sv
// Boot loader that receives a length-prefixed, XOR-checksummed byte stream and
// writes it as 32-bit words into core memory, holding the core in reset until a good load.
module nano_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_core_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WR, CSUM, DONE, ERR
    } state_t;

    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // One extra bit so the post-increment compare works when N == 2^ADDR_W.
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       word_q, word_d;
    logic              rx_ready_q, rx_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_full;

    assign accept   = i_rx_valid && rx_ready_q;
    assign len_full = {i_rx_data, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_rst_d  = core_rst_q;

        case (state_q)
            IDLE, ERR: begin
                if (i_start) begin
                    state_d    = LEN0;
                    len_d      = '0;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    core_rst_d = 1'b1;
                end
            end
            LEN0: begin
                if (accept) begin
                    len_d[7:0] = i_rx_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_d[15:8] = i_rx_data;
                    if (len_full == 16'd0)
                        state_d = CSUM;
                    else if (32'(len_full) > MAX_WORDS)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = i_rx_data;
                        2'd1:    word_d[15:8]  = i_rx_data;
                        2'd2:    word_d[23:16] = i_rx_data;
                        default: word_d[31:24] = i_rx_data;
                    endcase
                    csum_d     = csum_q ^ i_rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = WR;
                        mem_addr_d  = word_idx_q[ADDR_W-1:0];
                        mem_wdata_d = word_d;
                    end
                end
            end
            WR: begin
                word_idx_d = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
                if (32'(word_idx_q) + 32'd1 == 32'(len_q))
                    state_d = CSUM;
                else
                    state_d = DATA;
            end
            CSUM: begin
                if (accept)
                    state_d = (i_rx_data == csum_q) ? DONE : ERR;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rx_ready_d = (state_d == LEN0) || (state_d == LEN1) ||
                     (state_d == DATA) || (state_d == CSUM);
        busy_d     = rx_ready_d;
        mem_we_d   = (state_d == WR);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        if (state_d == DONE)
            core_rst_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_rx_ready  = rx_ready_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_core_rst  = core_rst_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule
